// File: rtl/fp_norm_round.sv
// ============================================================================
// Module   : fp_norm_round
// Purpose  : Two-stage normalize / round-to-nearest-even / pack for a
//            single-precision adder result, with valid/ready handshaking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_norm_round (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [27:0] i_mant_sum,
    input  logic        i_carry,
    input  logic        i_special,
    input  logic [31:0] i_special_val,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_underflow,
    output logic        o_inexact
);

    localparam logic signed [9:0] c_exp_max = 10'sd255;
    localparam logic signed [9:0] c_exp_min = 10'sd0;

    // Leading-zero count over a 27-bit field; all-zero returns 27.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        lzc27 = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) lzc27 = 5'(26 - i);
        end
    endfunction

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_load;
    logic w_s1_load;

    assign w_s2_load = !r_s2_valid || i_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign o_ready   = w_s1_load;
    assign o_valid   = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: normalize
    // ------------------------------------------------------------------
    logic [28:0]        w_sum;
    logic [4:0]         w_lzc;
    logic signed [9:0]  w_exp_in;
    logic signed [9:0]  w_lzc_ext;
    logic signed [9:0]  w_norm_exp;
    logic [26:0]        w_norm_mant;
    logic               w_zero;

    always_comb begin
        w_sum       = {i_carry, i_mant_sum};
        w_exp_in    = {2'b00, i_exp};
        w_lzc       = lzc27(w_sum[26:0]);
        w_lzc_ext   = {5'b00000, w_lzc};
        w_zero      = (w_sum == 29'd0);
        w_norm_mant = w_sum[26:0];
        w_norm_exp  = w_exp_in;
        if (w_sum[28]) begin
            w_norm_mant = {w_sum[28:3], |w_sum[2:0]};
            w_norm_exp  = w_exp_in + 10'sd2;
        end else if (w_sum[27]) begin
            w_norm_mant = {w_sum[27:2], |w_sum[1:0]};
            w_norm_exp  = w_exp_in + 10'sd1;
        end else begin
            w_norm_mant = w_sum[26:0] << w_lzc;
            w_norm_exp  = w_exp_in - w_lzc_ext;
        end
    end

    logic               r_s1_special;
    logic [31:0]        r_s1_special_val;
    logic               r_s1_sign;
    logic               r_s1_zero;
    logic signed [9:0]  r_s1_exp;
    logic [26:0]        r_s1_mant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid       <= 1'b0;
            r_s1_special     <= 1'b0;
            r_s1_special_val <= 32'h0;
            r_s1_sign        <= 1'b0;
            r_s1_zero        <= 1'b0;
            r_s1_exp         <= 10'sd0;
            r_s1_mant        <= 27'h0;
        end else if (w_s1_load) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_special     <= i_special;
                r_s1_special_val <= i_special_val;
                r_s1_sign        <= i_sign;
                r_s1_zero        <= w_zero;
                r_s1_exp         <= w_norm_exp;
                r_s1_mant        <= w_norm_mant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round to nearest even and pack
    // ------------------------------------------------------------------
    logic               w_g;
    logic               w_r;
    logic               w_s;
    logic               w_inc;
    logic [24:0]        w_sig;
    logic signed [9:0]  w_fexp;
    logic [31:0]        w_res;
    logic               w_ovf;
    logic               w_unf;
    logic               w_inx;

    always_comb begin
        w_g    = r_s1_mant[2];
        w_r    = r_s1_mant[1];
        w_s    = r_s1_mant[0];
        w_inc  = w_g && (w_r || w_s || r_s1_mant[3]);
        w_sig  = {1'b0, r_s1_mant[26:3]} + {24'h0, w_inc};
        // A carry out of the significand leaves exactly 1.0, one binade up.
        w_fexp = w_sig[24] ? (r_s1_exp + 10'sd1) : r_s1_exp;
        w_res  = 32'h0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_inx  = 1'b0;
        if (r_s1_special) begin
            w_res = r_s1_special_val;
        end else if (r_s1_zero) begin
            w_res = 32'h0;
        end else if (w_fexp >= c_exp_max) begin
            w_res = {r_s1_sign, 8'hFF, 23'h0};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_fexp <= c_exp_min) begin
            w_res = {r_s1_sign, 31'h0};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end else begin
            w_res = {r_s1_sign, w_fexp[7:0], (w_sig[24] ? 23'h0 : w_sig[22:0])};
            w_inx = w_g || w_r || w_s;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            o_result    <= 32'h0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_inexact   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                o_result    <= w_res;
                o_overflow  <= w_ovf;
                o_underflow <= w_unf;
                o_inexact   <= w_inx;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_round.sv
// ============================================================================
// Module   : tb_fp_norm_round
// Purpose  : Directed self-checking bench for fp_norm_round.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [27:0] i_mant_sum;
    logic        i_carry;
    logic        i_special;
    logic [31:0] i_special_val;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_norm_round dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_sign        (i_sign),
        .i_exp         (i_exp),
        .i_mant_sum    (i_mant_sum),
        .i_carry       (i_carry),
        .i_special     (i_special),
        .i_special_val (i_special_val),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_result      (o_result),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow),
        .o_inexact     (o_inexact)
    );

    // Packed view: {valid, overflow, underflow, inexact, result}
    task automatic check(input string tag, input logic [35:0] expected);
        logic [35:0] observed;
        observed = {o_valid, o_overflow, o_underflow, o_inexact, o_result};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                         input logic c, input logic sp, input logic [31:0] sv);
        i_valid       = 1'b1;
        i_sign        = s;
        i_exp         = e;
        i_mant_sum    = m;
        i_carry       = c;
        i_special     = sp;
        i_special_val = sv;
    endtask

    task automatic idle();
        i_valid       = 1'b0;
        i_sign        = 1'b0;
        i_exp         = 8'h0;
        i_mant_sum    = 28'h0;
        i_carry       = 1'b0;
        i_special     = 1'b0;
        i_special_val = 32'h0;
    endtask

    // One transaction with i_ready=1: not visible after one edge, visible after two.
    task automatic single(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] m, input logic c, input logic sp,
                          input logic [31:0] sv, input logic [35:0] expected);
        drive(s, e, m, c, sp, sv);
        @(negedge clk);
        idle();
        check_bit({tag, "_lat1"}, o_valid, 1'b0);
        @(negedge clk);
        check(tag, expected);
    endtask

    initial begin
        rst     = 1'b1;
        i_ready = 1'b1;
        idle();
        // Valid held high during reset must not be accepted.
        drive(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 36'h0);
        check_bit("reset_ready", o_ready, 1'b1);
        idle();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("no_accept_in_reset", o_valid, 1'b0);

        single("bit27_shift", 1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b000, 32'h40000000});
        single("tie_even",    1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b001, 32'h3F800000});
        single("tie_up",      1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b001, 32'h3F800002});
        single("cancel_lzc23",1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b000, 32'h34000000});
        single("zero_sum",    1'b1, 8'd127, 28'h0000000, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b000, 32'h00000000});
        single("carry_case",  1'b1, 8'd127, 28'h0000003, 1'b1, 1'b0, 32'h0,
               {1'b1, 3'b001, 32'hC0800000});
        single("round_carry", 1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b001, 32'h40000000});
        single("overflow",    1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b101, 32'h7F800000});
        single("underflow",   1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0, 32'h0,
               {1'b1, 3'b011, 32'h00000000});
        single("bypass_nan",  1'b0, 8'd254, 28'h8000000, 1'b0, 1'b1, 32'h7FC00000,
               {1'b1, 3'b000, 32'h7FC00000});
        @(negedge clk);
        check_bit("drained", o_valid, 1'b0);

        // Backpressure: three back-to-back inputs while downstream stalls.
        i_ready = 1'b0;
        drive(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h0);
        check_bit("bp_ready0", o_ready, 1'b1);
        @(negedge clk);
        check_bit("bp_ready1", o_ready, 1'b1);
        drive(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_bit("bp_ready_fall", o_ready, 1'b0);
        check("bp_first_out", {1'b1, 3'b000, 32'h40000000});
        drive(1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_stable", {1'b1, 3'b000, 32'h40000000});
            check_bit("bp_ready_low", o_ready, 1'b0);
        end
        i_ready = 1'b1;
        #1;
        check_bit("bp_ready_release", o_ready, 1'b1);
        @(negedge clk);
        idle();
        check("bp_second_out", {1'b1, 3'b001, 32'h3F800000});
        @(negedge clk);
        check("bp_third_out", {1'b1, 3'b000, 32'h34000000});
        @(negedge clk);
        check_bit("bp_done", o_valid, 1'b0);

        // Reset with both stages occupied.
        i_ready = 1'b0;
        drive(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        drive(1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        idle();
        check_bit("full_before_rst", o_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("async_reset", 36'h0);
        check_bit("rst_ready", o_ready, 1'b1);
        @(negedge clk);
        rst     = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_bit("no_stale", o_valid, 1'b0);
        end

        single("post_rst_bypass", 1'b0, 8'd0, 28'h0, 1'b0, 1'b1, 32'h7FC00000,
               {1'b1, 3'b000, 32'h7FC00000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
